// File: rtl/stack_arb.sv
// Two-requester arbiter in front of an external stack: push/pop/top-of-stack with depth tracking.
// Define STACK_ARB_FIXED_PRIO_EN to give requester 0 priority on ties; default is round-robin.
module stack_arb #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     req1,
  input  logic [1:0]               op0,
  input  logic [1:0]               op1,
  input  logic [DW-1:0]            wdata0,
  input  logic [DW-1:0]            wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     done0,
  output logic                     done1,
  output logic                     err,
  output logic [DW-1:0]            rdata,
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic                     stk_tos,
  output logic [DW-1:0]            stk_din,
  input  logic [DW-1:0]            stk_dout,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_TOS  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam logic [AW-1:0] DEPTH_MAX = AW'(DEPTH);

  logic [1:0]    state_reg, state_next;
  logic          owner_reg;
  logic [1:0]    op_reg;
  logic [DW-1:0] wdata_reg;
  logic          legal_reg;
  logic          last_reg;
  logic [AW-1:0] depth_reg;
  logic [DW-1:0] rdata_reg;

  logic          any_req;
  logic          win_next;
  logic [1:0]    op_sel;
  logic [DW-1:0] wdata_sel;
  logic          legal_sel;

  logic          in_issue;
  logic          in_done;
  logic [1:0]    gnt_vec;
  logic [1:0]    done_vec;

  assign any_req = req0 | req1;

  // Tie-break: fixed priority or the requester not served last.
  always_comb begin
    win_next = 1'b0;
    if (req0 && req1) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
      win_next = 1'b0;
`else
      win_next = ~last_reg;
`endif
    end else if (req1) begin
      win_next = 1'b1;
    end
  end

  assign op_sel    = win_next ? op1    : op0;
  assign wdata_sel = win_next ? wdata1 : wdata0;

  always_comb begin
    legal_sel = 1'b1;
    case (op_sel)
      OP_PUSH: legal_sel = (depth_reg != DEPTH_MAX);
      OP_POP:  legal_sel = (depth_reg != '0);
      OP_TOS:  legal_sel = (depth_reg != '0);
      OP_NOP:  legal_sel = 1'b1;
      default: legal_sel = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (any_req) state_next = S_ISSUE;
      S_ISSUE: state_next = (op_reg == OP_TOS) ? S_WAIT : S_DONE;
      S_WAIT:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      owner_reg <= 1'b0;
      op_reg    <= OP_NOP;
      wdata_reg <= '0;
      legal_reg <= 1'b0;
      last_reg  <= 1'b1;
      depth_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && any_req) begin
        owner_reg <= win_next;
        op_reg    <= op_sel;
        wdata_reg <= wdata_sel;
        legal_reg <= legal_sel;
        last_reg  <= win_next;
      end
      // Legality was decided at acceptance, so depth can never wrap here.
      if (state_reg == S_ISSUE && legal_reg) begin
        case (op_reg)
          OP_PUSH: depth_reg <= depth_reg + 1'b1;
          OP_POP:  depth_reg <= depth_reg - 1'b1;
          default: depth_reg <= depth_reg;
        endcase
      end
      if (state_reg == S_WAIT && legal_reg) begin
        rdata_reg <= stk_dout;
      end
    end
  end

  assign in_issue = (state_reg == S_ISSUE);
  assign in_done  = (state_reg == S_DONE);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign gnt_vec[gi]  = in_issue && (owner_reg == 1'(gi));
      assign done_vec[gi] = in_done  && (owner_reg == 1'(gi));
    end
  endgenerate

  assign gnt0  = gnt_vec[0];
  assign gnt1  = gnt_vec[1];
  assign done0 = done_vec[0];
  assign done1 = done_vec[1];

  assign err      = in_done && !legal_reg;
  assign stk_push = in_issue && legal_reg && (op_reg == OP_PUSH);
  assign stk_pop  = in_issue && legal_reg && (op_reg == OP_POP);
  assign stk_tos  = in_issue && legal_reg && (op_reg == OP_TOS);
  assign stk_din  = wdata_reg;

  assign rdata = rdata_reg;
  assign depth = depth_reg;
  assign full  = (depth_reg == DEPTH_MAX);
  assign empty = (depth_reg == '0);

endmodule

// File: tb/tb_stack_arb.sv
// Bench for stack_arb: transaction-level schedule model checked every cycle, plus directed literal checks.
// Build with STACK_ARB_FIXED_PRIO_EN defined to check the fixed-priority tie order.
module tb_stack_arb;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int MAXC  = 4000;
  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] TOS  = 2'b10;
  localparam logic [1:0] NOP  = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = NOP, op1 = NOP;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, done0, done1, err;
  logic [DW-1:0] rdata;
  logic stk_push, stk_pop, stk_tos;
  logic [DW-1:0] stk_din;
  logic [DW-1:0] stk_dout;
  logic [3:0] depth;
  logic full, empty;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  stack_arb #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err(err), .rdata(rdata),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos),
    .stk_din(stk_din), .stk_dout(stk_dout),
    .depth(depth), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s cyc=%0d actual=timeout required=event", nm, cyc);
  endtask

  // External stack memory with registered read, sharing the reset.
  logic [DW-1:0] smem [0:15];
  int sp = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp = 0;
      stk_dout <= '0;
    end else begin
      if (stk_tos && sp > 0) stk_dout <= smem[sp-1];
      if (stk_push && sp < 16) begin smem[sp] = stk_din; sp++; end
      if (stk_pop && sp > 0) sp--;
    end
  end

  // Schedule model: each accepted transaction writes its expected outputs into per-cycle slots.
  bit eg0[MAXC], eg1[MAXC], ed0[MAXC], ed1[MAXC], eerr[MAXC];
  bit epush[MAXC], epop[MAXC], etos[MAXC], rdset[MAXC];
  logic [DW-1:0] edin[MAXC];
  logic [DW-1:0] rdval[MAXC];
  int ddelta[MAXC];
  logic [DW-1:0] mstack[$];
  int mdepth_vis = 0;
  logic [DW-1:0] mrd = '0;
  int mlast = 1;
  int busy_next = 0;

  always @(negedge rst) begin
    for (int i = cyc; i < MAXC; i++) begin
      eg0[i] = 0; eg1[i] = 0; ed0[i] = 0; ed1[i] = 0; eerr[i] = 0;
      epush[i] = 0; epop[i] = 0; etos[i] = 0; rdset[i] = 0; ddelta[i] = 0;
    end
    mstack.delete();
    mdepth_vis = 0;
    mrd = '0;
    mlast = 1;
    busy_next = 0;
  end

  always @(posedge clk) begin
    int w, k, d;
    logic [1:0] o;
    logic [DW-1:0] wd;
    bit lg;
    cyc++;
    if (rst) begin
      mdepth_vis += ddelta[cyc];
      if (rdset[cyc]) mrd = rdval[cyc];
      if (cyc >= busy_next && (req0 || req1)) begin
        if (req0 && req1) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
          w = 0;
`else
          w = (mlast == 1) ? 0 : 1;
`endif
        end else begin
          w = req1 ? 1 : 0;
        end
        mlast = w;
        o  = (w == 1) ? op1 : op0;
        wd = (w == 1) ? wdata1 : wdata0;
        case (o)
          PUSH:    lg = (mstack.size() < DEPTH);
          POP:     lg = (mstack.size() > 0);
          TOS:     lg = (mstack.size() > 0);
          default: lg = 1;
        endcase
        k = cyc;
        if (w == 1) eg1[k] = 1; else eg0[k] = 1;
        if (lg) begin
          case (o)
            PUSH: begin epush[k] = 1; edin[k] = wd; mstack.push_back(wd); ddelta[k+1] += 1; end
            POP:  begin epop[k] = 1; void'(mstack.pop_back()); ddelta[k+1] -= 1; end
            TOS:  begin etos[k] = 1; rdset[k+2] = 1; rdval[k+2] = mstack[$]; end
            default: ;
          endcase
        end
        d = (o == TOS) ? k + 2 : k + 1;
        if (w == 1) ed1[d] = 1; else ed0[d] = 1;
        eerr[d] = !lg;
        busy_next = d + 2;
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt0", gnt0, eg0[cyc]);
    chk("gnt1", gnt1, eg1[cyc]);
    chk("done0", done0, ed0[cyc]);
    chk("done1", done1, ed1[cyc]);
    chk("stk_push", stk_push, epush[cyc]);
    chk("stk_pop", stk_pop, epop[cyc]);
    chk("stk_tos", stk_tos, etos[cyc]);
    chk("depth", depth, mdepth_vis);
    chk("full", full, mdepth_vis == DEPTH);
    chk("empty", empty, mdepth_vis == 0);
    chk("rdata", rdata, mrd);
    if (epush[cyc]) chk("stk_din", stk_din, edin[cyc]);
    if (ed0[cyc] || ed1[cyc]) chk("err", err, eerr[cyc]);
  end

  task automatic issue(input int r, input logic [1:0] o, input logic [DW-1:0] wd,
                       output int t0, output int gs, output int ds,
                       output logic e, output logic [DW-1:0] rd);
    @(posedge clk); #1;
    t0 = cyc;
    gs = -1; ds = -1; e = 1'b0; rd = '0;
    if (r == 0) begin req0 = 1'b1; op0 = o; wdata0 = wd; end
    else        begin req1 = 1'b1; op1 = o; wdata1 = wd; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((r == 0) ? gnt0 : gnt1) begin gs = cyc; break; end
    end
    if (gs < 0) timeout_fail("gnt_wait");
    @(posedge clk); #1;
    if (r == 0) req0 = 1'b0; else req1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((r == 0) ? done0 : done1) begin ds = cyc; e = err; rd = rdata; break; end
    end
    if (ds < 0) timeout_fail("done_wait");
    $display("txn req%0d op=%0d wdata=%02h sample=%0d gnt=%0d done=%0d err=%0b rdata=%02h depth=%0d",
             r, o, wd, t0 + 1, gs, ds, e, rd, depth);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, gs, ds, n;
    logic e;
    logic [DW-1:0] rd;
    int order[4];
    int exp_order[4];

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_depth", depth, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_gnt0", gnt0, 0);
    #1 rst = 1'b1;

    // Push 0xA5 from requester 0: gnt at N+1, done at N+2.
    issue(0, PUSH, 8'hA5, t0, gs, ds, e, rd);
    chk("push_gnt_lat", gs, t0 + 1);
    chk("push_done_lat", ds, t0 + 2);
    chk("push_err", e, 0);
    chk("push_depth", depth, 1);

    // Top-of-stack from requester 1: done at N+3 with the pushed value.
    issue(1, TOS, 8'h00, t0, gs, ds, e, rd);
    chk("tos_gnt_lat", gs, t0 + 1);
    chk("tos_done_lat", ds, t0 + 3);
    chk("tos_rdata", rd, 8'hA5);
    chk("tos_err", e, 0);

    // Empty the stack, then illegal pop and tos.
    issue(0, POP, 8'h00, t0, gs, ds, e, rd);
    chk("pop_err", e, 0);
    chk("pop_depth", depth, 0);
    issue(1, POP, 8'h00, t0, gs, ds, e, rd);
    chk("pop_empty_err", e, 1);
    chk("pop_empty_depth", depth, 0);
    issue(0, TOS, 8'h00, t0, gs, ds, e, rd);
    chk("tos_empty_err", e, 1);
    chk("tos_empty_lat", ds, t0 + 3);
    chk("tos_empty_rdata", rd, 8'hA5);

    // Fill to capacity, then overflow.
    for (int i = 0; i < DEPTH; i++) begin
      issue(i % 2, PUSH, 8'h10 + 8'(i), t0, gs, ds, e, rd);
      chk("fill_err", e, 0);
    end
    chk("fill_full", full, 1);
    chk("fill_depth", depth, 8);
    issue(0, PUSH, 8'hEE, t0, gs, ds, e, rd);
    chk("over_err", e, 1);
    chk("over_depth", depth, 8);
    issue(1, TOS, 8'h00, t0, gs, ds, e, rd);
    chk("full_tos_rdata", rd, 8'h17);

    // Both requesters held together for four pops.
`ifdef STACK_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    @(posedge clk); #1;
    req0 = 1'b1; op0 = POP; req1 = 1'b1; op1 = POP;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (gnt0) begin order[n] = 0; n++; end
      else if (gnt1) begin order[n] = 1; n++; end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    if (n < 4) timeout_fail("tie_grants");
    for (int i = 0; i < n; i++) begin
      chk("tie_order", order[i], exp_order[i]);
      $display("txn tie grant %0d -> req%0d", i, order[i]);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("tie_depth", depth, 4);

    // Reset during the WAIT cycle of a tos.
    @(posedge clk); #1;
    req0 = 1'b1; op0 = TOS;
    gs = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt0) begin gs = cyc; break; end
    end
    if (gs < 0) timeout_fail("rst_tos_gnt");
    @(posedge clk); #2;
    req0 = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_depth", depth, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_done0", done0, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_tos", stk_tos, 0);
    $display("txn reset during tos wait cyc=%0d depth=%0d rdata=%02h", cyc, depth, rdata);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_nodone", done0, 0);
    end
    @(posedge clk); #2;
    rst = 1'b1;

    issue(1, PUSH, 8'h3C, t0, gs, ds, e, rd);
    chk("post_rst_push_err", e, 0);
    chk("post_rst_depth", depth, 1);
    issue(0, TOS, 8'h00, t0, gs, ds, e, rd);
    chk("post_rst_tos_rdata", rd, 8'h3C);
    chk("post_rst_tos_lat", ds, t0 + 3);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
